// File: rtl/pico_ctrl_seq.sv
// Sequential picoMIPS control unit: opcode decode with multiplier stall and SW8 ready handshake.
// Optional macro PICO_READY_SYNC_EN puts `ready` through a 2-flop synchroniser before use.
module pico_ctrl_seq #(
  parameter int OPW     = 6,
  parameter int AFW     = 3,
  parameter int MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic [OPW-1:0] opcode,
  input  logic [3:0]     flags,
  input  logic           ready,
  input  logic           branch_cond,
  output logic           pc_incr,
  output logic           pc_rel,
  output logic           pc_abs,
  output logic [AFW-1:0] alu_func,
  output logic           w,
  output logic           imm,
  output logic           store,
  output logic           disp,
  output logic           busy
);

  // state     | meaning
  // S_RUN     | normal combinational decode of opcode
  // S_MUL     | multiplier stall, counting down to the write cycle
  // S_WAIT_HI | WAITR issued, waiting for ready=1
  // S_WAIT_LO | ready seen high, waiting for ready=0 to release
  typedef enum logic [1:0] {S_RUN, S_MUL, S_WAIT_HI, S_WAIT_LO} state_t;

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (MUL_LAT > 1) ? CW'(MUL_LAT - 2) : '0;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(3);
  localparam logic [OPW-1:0] OP_SUBI  = OPW'(4);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(5);
  localparam logic [OPW-1:0] OP_MULI  = OPW'(6);
  localparam logic [OPW-1:0] OP_SHOW  = OPW'(7);
  localparam logic [OPW-1:0] OP_ADDS  = OPW'(8);
  localparam logic [OPW-1:0] OP_BREL  = OPW'(9);
  localparam logic [OPW-1:0] OP_BABS  = OPW'(10);
  localparam logic [OPW-1:0] OP_WAITR = OPW'(11);

  localparam logic [AFW-1:0] RNOP = AFW'(0);
  localparam logic [AFW-1:0] RADD = AFW'(1);
  localparam logic [AFW-1:0] RSUB = AFW'(2);
  localparam logic [AFW-1:0] RMUL = AFW'(3);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          mul_imm, mul_imm_nx;
  logic [3:0]    flags_q;
  logic          ready_use;
  logic          unused_flags;

`ifdef PICO_READY_SYNC_EN
  logic [1:0] ready_sync;

  always_ff @(posedge clk) begin
    if (!n_reset) ready_sync <= '0;
    else          ready_sync <= {ready_sync[0], ready};
  end

  assign ready_use = ready_sync[1];
`else
  assign ready_use = ready;
`endif

  // Flags are captured for future conditional ops but have no decode effect yet.
  assign unused_flags = ^flags_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state   <= S_RUN;
      cnt     <= '0;
      mul_imm <= 1'b0;
      flags_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      mul_imm <= mul_imm_nx;
      flags_q <= flags;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    mul_imm_nx = mul_imm;
    pc_incr    = 1'b1;
    pc_rel     = 1'b0;
    pc_abs     = 1'b0;
    alu_func   = RNOP;
    w          = 1'b0;
    imm        = 1'b0;
    store      = 1'b0;
    disp       = 1'b0;

    case (state)
      S_RUN: begin
        case (opcode)
          OP_ADD:  begin alu_func = RADD; w = 1'b1; end
          OP_ADDI: begin alu_func = RADD; w = 1'b1; imm = 1'b1; end
          OP_SUB:  begin alu_func = RSUB; w = 1'b1; end
          OP_SUBI: begin alu_func = RSUB; w = 1'b1; imm = 1'b1; end
          OP_MUL, OP_MULI: begin
            alu_func = RMUL;
            imm      = (opcode == OP_MULI);
            if (MUL_LAT > 1) begin
              pc_incr    = 1'b0;
              state_nx   = S_MUL;
              cnt_nx     = CNT_LOAD;
              mul_imm_nx = (opcode == OP_MULI);
            end else begin
              w = 1'b1;
            end
          end
          OP_SHOW: begin alu_func = RADD; disp = 1'b1; end
          OP_ADDS: begin alu_func = RADD; w = 1'b1; imm = 1'b1; store = 1'b1; end
          OP_BREL: begin
            if (ready_use == branch_cond) begin
              pc_rel  = 1'b1;
              pc_incr = 1'b0;
            end
          end
          OP_BABS: begin pc_abs = 1'b1; pc_incr = 1'b0; end
          OP_WAITR: begin
            pc_incr  = 1'b0;
            state_nx = S_WAIT_HI;
          end
          default: ;
        endcase
      end
      S_MUL: begin
        alu_func = RMUL;
        imm      = mul_imm;
        pc_incr  = 1'b0;
        if (cnt == '0) begin
          w        = 1'b1;
          pc_incr  = 1'b1;
          state_nx = S_RUN;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_WAIT_HI: begin
        pc_incr = 1'b0;
        if (ready_use) state_nx = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        pc_incr = 1'b0;
        if (!ready_use) begin
          pc_incr  = 1'b1;
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_RUN;
    endcase

    // While reset is held the datapath sees a plain NOP, so an aborted MUL never writes.
    if (!n_reset) begin
      pc_incr  = 1'b1;
      pc_rel   = 1'b0;
      pc_abs   = 1'b0;
      alu_func = RNOP;
      w        = 1'b0;
      imm      = 1'b0;
      store    = 1'b0;
      disp     = 1'b0;
    end
  end

  assign busy = (state != S_RUN);

endmodule
